// File: rtl/mux3_hold_pkg.sv
// Shared select-code definitions for the 3-to-1 hold mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_D0      = 2'b00;
  localparam sel_t SEL_D1      = 2'b01;
  localparam sel_t SEL_D2      = 2'b10;
  localparam sel_t SEL_INVALID = 2'b11;

  // True for the three codes that name a real data input.
  function automatic logic sel_is_legal(input sel_t s);
    return (s != SEL_INVALID);
  endfunction

endpackage

// File: rtl/mux3_hold_if.sv
// Bundles the data inputs, the select code and the status outputs of mux3_hold.
// Latency: n/a (wiring only).
// Backpressure: none; there is no handshake on this bus.
// Ports: d0/d1/d2 data, s select, y selected data, sel_invalid,
//        last_sel, invalid_count status.
interface mux3_hold_if
  import mux_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
);

  logic [WIDTH-1:0]     d0;
  logic [WIDTH-1:0]     d1;
  logic [WIDTH-1:0]     d2;
  sel_t                 s;
  logic [WIDTH-1:0]     y;
  logic                 sel_invalid;
  sel_t                 last_sel;
  logic [CNT_WIDTH-1:0] invalid_count;

  // Driver side: supplies data and select, observes result and status.
  modport master (
    output d0, d1, d2, s,
    input  y, sel_invalid, last_sel, invalid_count
  );

  // Mux side.
  modport slave (
    input  d0, d1, d2, s,
    output y, sel_invalid, last_sel, invalid_count
  );

endinterface

// File: rtl/mux3_hold_sat_counter.sv
// Saturating up-counter: counts clock edges with inc high, sticks at all-ones.
// Latency: count updates one clk edge after inc is sampled.
// Backpressure: none; inc is sampled every edge.
// Ports: clk, reset (sync, active-high), inc, count.
module sat_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mux3_hold.sv
// 3-to-1 data selector; the illegal code 2'b11 keeps passing the last legal input.
// Latency: y and sel_invalid are combinational; last_sel/invalid_count update on clk.
// Backpressure: none; every input is consumed as presented.
// Ports: clk, reset (sync, active-high), bus (slave side of mux3_hold_if).
module mux3_hold
  import mux_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic  clk,
  input  logic  reset,
  mux3_hold_if.slave bus
);

  sel_t last_sel_q;
  sel_t eff_sel;
  logic legal;

  assign legal           = sel_is_legal(bus.s);
  assign bus.sel_invalid = ~legal;
  assign bus.last_sel    = last_sel_q;

  // On the illegal code the live data of the remembered input is routed, so
  // a change on that input still reaches y without waiting for a clock.
  always_comb begin
    eff_sel = bus.s;
    if (!legal) begin
      eff_sel = last_sel_q;
    end
    case (eff_sel)
      SEL_D0:  bus.y = bus.d0;
      SEL_D1:  bus.y = bus.d1;
      default: bus.y = bus.d2;
    endcase
  end

  // Reset lands on d2 so illegal selects right after reset have a defined
  // source; only legal codes are ever loaded, so 2'b11 is never stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_sel_q <= SEL_D2;
    end else if (legal) begin
      last_sel_q <= bus.s;
    end
  end

  sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_invalid_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~legal),
    .count (bus.invalid_count)
  );

endmodule

// File: tb/tb_mux3_hold.sv
// Directed bench for mux3_hold with an expected-value scoreboard queue.
// Latency: checks combinational outputs 1ns after drive, registered ones after edges.
// Backpressure: n/a.
module tb_mux3_hold;

  localparam int WIDTH     = 32;
  localparam int CNT_WIDTH = 8;

  typedef enum logic [1:0] {K_Y, K_SI, K_LS, K_CNT} kind_t;

  typedef struct {
    string       tag;
    kind_t       kind;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  exp_t sb[$];

  mux3_hold_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  mux3_hold #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input kind_t kind, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Pop every pending expectation and compare against the DUT outputs.
  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_Y:     obs = bus.y;
        K_SI:    obs = {31'b0, bus.sel_invalid};
        K_LS:    obs = {30'b0, bus.last_sel};
        default: obs = 32'(bus.invalid_count);
      endcase
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance n rising edges, then settle at the following falling edge.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.d0 = '0;
    bus.d1 = '0;
    bus.d2 = '0;
    bus.s  = 2'b00;
    edges(2);
    reset = 1'b0;
    push("reset_last_sel", K_LS, 32'h2);
    push("reset_count", K_CNT, 32'h0);
    check_all();

    // Legal selects pass the matching input; last_sel follows after the edge.
    bus.d0 = 32'd1;
    bus.d1 = 32'd2;
    bus.d2 = 32'd4;
    bus.s  = 2'b00;
    push("y_s00", K_Y, 32'd1);
    push("si_s00", K_SI, 32'd0);
    check_all();
    edges(1);
    push("ls_s00", K_LS, 32'h0);
    check_all();

    bus.s = 2'b01;
    push("y_s01", K_Y, 32'd2);
    push("si_s01", K_SI, 32'd0);
    check_all();
    edges(1);
    push("ls_s01", K_LS, 32'h1);
    check_all();

    bus.s = 2'b10;
    push("y_s10", K_Y, 32'd4);
    push("si_s10", K_SI, 32'd0);
    check_all();
    edges(1);
    push("ls_s10", K_LS, 32'h2);
    check_all();

    // Data change with no clock edge.
    bus.d2 = 32'd16;
    push("y_d2_live", K_Y, 32'd16);
    check_all();

    // Illegal select holds d2 for three edges.
    bus.s = 2'b11;
    push("y_hold_d2", K_Y, 32'd16);
    push("si_illegal", K_SI, 32'd1);
    check_all();
    edges(3);
    push("y_hold_d2_3", K_Y, 32'd16);
    push("ls_hold_d2", K_LS, 32'h2);
    push("cnt_3", K_CNT, 32'd3);
    check_all();
    bus.d2 = 32'd5;
    push("y_hold_d2_live", K_Y, 32'd5);
    check_all();

    // Retarget the hold to d0.
    bus.s = 2'b00;
    edges(1);
    push("cnt_hold_legal", K_CNT, 32'd3);
    check_all();
    bus.s = 2'b11;
    push("y_hold_d0", K_Y, 32'd1);
    push("ls_d0", K_LS, 32'h0);
    check_all();
    bus.d0 = 32'd7;
    push("y_hold_d0_live", K_Y, 32'd7);
    check_all();

    // Saturation: 3 + 251 = 254, one more = 255, then stuck.
    edges(251);
    push("cnt_254", K_CNT, 32'd254);
    check_all();
    edges(1);
    push("cnt_255", K_CNT, 32'd255);
    check_all();
    edges(9);
    push("cnt_no_wrap", K_CNT, 32'd255);
    push("ls_no_11", K_LS, 32'h0);
    check_all();

    // Reset beats a legal select on the same edge; y stays combinational.
    bus.s = 2'b01;
    reset = 1'b1;
    push("y_during_reset", K_Y, 32'd2);
    check_all();
    edges(1);
    push("ls_reset_wins", K_LS, 32'h2);
    push("cnt_reset", K_CNT, 32'd0);
    push("y_after_reset", K_Y, 32'd2);
    check_all();
    reset = 1'b0;

    // After reset, illegal select passes d2 and counts from zero.
    bus.s = 2'b11;
    push("y_post_reset_d2", K_Y, 32'd5);
    check_all();
    edges(1);
    push("cnt_post_reset", K_CNT, 32'd1);
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
